// File: rtl/trig_gen_if.sv
// rtl/trig_gen_if.sv - sample, settings and trigger signal bundle for trig_gen
interface trig_gen_if #(
    parameter int HOLDOFF_W = 16
);
    logic [7:0]           ad_data;
    logic                 arm;
    logic [7:0]           trig_level;
    logic                 trig_edge;
    logic [3:0]           hyst;
    logic [HOLDOFF_W-1:0] holdoff;
    logic                 auto_en;
    logic                 trigger;
    logic                 auto_flag;
    logic                 armed;
    logic [15:0]          trig_cnt;

    modport master (
        output ad_data, arm, trig_level, trig_edge, hyst, holdoff, auto_en,
        input  trigger, auto_flag, armed, trig_cnt
    );

    modport slave (
        input  ad_data, arm, trig_level, trig_edge, hyst, holdoff, auto_en,
        output trigger, auto_flag, armed, trig_cnt
    );
endinterface

// File: rtl/trig_gen.sv
// rtl/trig_gen.sv - level-crossing trigger generator with hysteresis, hold-off and auto-trigger
module trig_gen #(
    parameter int HOLDOFF_W = 16,
    parameter int AUTO_CYC  = 50000
) (
    input  logic      I_clk,
    input  logic      rst_n,
    trig_gen_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_READY   = 3'd2,
        S_FIRE    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    localparam logic [19:0] TMO_LAST = 20'(AUTO_CYC - 1);

    state_t               state;
    state_t               next_state;
    logic [7:0]           ad_q;
    logic [7:0]           lvl_q;
    logic                 edge_q;
    logic [3:0]           hyst_q;
    logic [19:0]          tmo_cnt;
    logic [HOLDOFF_W-1:0] hold_cnt;
    logic                 trigger_q;
    logic                 auto_q;
    logic [15:0]          cnt_q;
    logic                 armed_c;

    logic [8:0]           low_diff;
    logic [8:0]           high_sum;
    logic [7:0]           low_bnd;
    logic [7:0]           high_bnd;
    logic                 prime_hit;
    logic                 cross_hit;
    logic                 tmo_hit;
    logic                 hold_done;
    logic                 fire_auto;
    logic                 enter_armed;
    logic                 searching_next;

    // Hysteresis bounds (saturating) and the crossing/timeout conditions seen by the FSM
    always_comb begin
        low_diff  = {1'b0, lvl_q} - {5'b0, hyst_q};
        high_sum  = {1'b0, lvl_q} + {5'b0, hyst_q};
        low_bnd   = low_diff[8] ? 8'h00 : low_diff[7:0];
        high_bnd  = high_sum[8] ? 8'hFF : high_sum[7:0];
        prime_hit = edge_q ? (ad_q >= high_bnd) : (ad_q <= low_bnd);
        cross_hit = edge_q ? (ad_q <= lvl_q) : (ad_q >= lvl_q);
        tmo_hit   = bus.auto_en && (tmo_cnt == TMO_LAST);
        hold_done = ({1'b0, hold_cnt} + {{HOLDOFF_W{1'b0}}, 1'b1}) >= {1'b0, bus.holdoff};
    end

    // State register
    always_ff @(posedge I_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: dropping arm wins over a crossing or timeout; a real crossing wins over timeout
    always_comb begin
        next_state = state;
        fire_auto  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.arm) next_state = S_ARMED;
            end
            S_ARMED: begin
                if (!bus.arm) begin
                    next_state = S_IDLE;
                end else if (tmo_hit) begin
                    next_state = S_FIRE;
                    fire_auto  = 1'b1;
                end else if (prime_hit) begin
                    next_state = S_READY;
                end
            end
            S_READY: begin
                if (!bus.arm) begin
                    next_state = S_IDLE;
                end else if (cross_hit) begin
                    next_state = S_FIRE;
                end else if (tmo_hit) begin
                    next_state = S_FIRE;
                    fire_auto  = 1'b1;
                end
            end
            S_FIRE: begin
                if (bus.holdoff != '0) next_state = S_HOLDOFF;
                else if (bus.arm)      next_state = S_ARMED;
                else                   next_state = S_IDLE;
            end
            S_HOLDOFF: begin
                if (!bus.arm)      next_state = S_IDLE;
                else if (hold_done) next_state = S_ARMED;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        armed_c = (state == S_ARMED) || (state == S_READY);
    end

    assign enter_armed    = (next_state == S_ARMED) && (state != S_ARMED);
    assign searching_next = (next_state == S_ARMED) || (next_state == S_READY);

    // Sample register and settings snapshot taken on every entry to ARMED
    always_ff @(posedge I_clk or negedge rst_n) begin
        if (!rst_n) begin
            ad_q   <= 8'h00;
            lvl_q  <= 8'h00;
            edge_q <= 1'b0;
            hyst_q <= 4'h0;
        end else begin
            ad_q <= bus.ad_data;
            if (enter_armed) begin
                lvl_q  <= bus.trig_level;
                edge_q <= bus.trig_edge;
                hyst_q <= bus.hyst;
            end
        end
    end

    // Timeout counter runs only while searching with auto_en set; hold-off counter only in HOLDOFF
    always_ff @(posedge I_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            if (armed_c && searching_next && bus.auto_en) tmo_cnt <= tmo_cnt + 20'd1;
            else                                          tmo_cnt <= '0;
            if ((state == S_HOLDOFF) && (next_state == S_HOLDOFF)) hold_cnt <= hold_cnt + 1'b1;
            else                                                   hold_cnt <= '0;
        end
    end

    // Trigger pulse, auto flag and trigger count all registered at FIRE entry
    always_ff @(posedge I_clk or negedge rst_n) begin
        if (!rst_n) begin
            trigger_q <= 1'b0;
            auto_q    <= 1'b0;
            cnt_q     <= 16'h0000;
        end else begin
            trigger_q <= (next_state == S_FIRE);
            if (next_state == S_FIRE) begin
                auto_q <= fire_auto;
                cnt_q  <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.trigger   = trigger_q;
    assign bus.auto_flag = auto_q;
    assign bus.armed     = armed_c;
    assign bus.trig_cnt  = cnt_q;
endmodule

// File: tb/tb_trig_gen.sv
// tb/tb_trig_gen.sv - self-checking bench for trig_gen with behavioural reference model
module tb_trig_gen;
    localparam int AUTO = 100;

    logic I_clk = 1'b0;
    logic rst_n = 1'b0;

    trig_gen_if #(.HOLDOFF_W(16)) bus();

    trig_gen #(.HOLDOFF_W(16), .AUTO_CYC(AUTO)) dut (
        .I_clk (I_clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 I_clk = ~I_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model state: searching window, primed by hysteresis, firing, dead time left
    bit m_search, m_primed, m_fire, m_auto;
    int m_dead, m_since, m_cnt, m_lvl, m_edge, m_hyst, m_adq;

    // pulse trackers
    int pulse_n, last_cyc, min_gap;
    int p_cyc[8];
    bit prev_trig, wide;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic start_search();
        m_search = 1; m_primed = 0; m_since = 0;
        m_lvl  = int'(bus.trig_level);
        m_edge = int'(bus.trig_edge);
        m_hyst = int'(bus.hyst);
    endtask

    task automatic model_step();
        int  lo, hi;
        bit  prime, crossed, timed;
        lo = (m_lvl - m_hyst < 0) ? 0 : m_lvl - m_hyst;
        hi = (m_lvl + m_hyst > 255) ? 255 : m_lvl + m_hyst;
        prime   = m_edge ? (m_adq >= hi) : (m_adq <= lo);
        crossed = m_primed && (m_edge ? (m_adq <= m_lvl) : (m_adq >= m_lvl));
        timed   = bus.auto_en && (m_since == AUTO - 1);
        if (m_fire) begin
            m_fire = 0;
            if (bus.holdoff != 0) m_dead = int'(bus.holdoff);
            else if (bus.arm)     start_search();
        end else if (m_dead > 0) begin
            if (!bus.arm) m_dead = 0;
            else begin
                m_dead--;
                if (m_dead == 0) start_search();
            end
        end else if (m_search) begin
            if (!bus.arm) begin
                m_search = 0;
            end else if (crossed || timed) begin
                m_fire = 1; m_auto = !crossed; m_cnt++;
                m_search = 0;
            end else begin
                if (prime) m_primed = 1;
                m_since = bus.auto_en ? m_since + 1 : 0;
            end
        end else if (bus.arm) begin
            start_search();
        end
        m_adq = int'(bus.ad_data);
    endtask

    initial begin
        forever begin
            @(posedge I_clk or negedge rst_n);
            if (!rst_n) begin
                m_search = 0; m_primed = 0; m_fire = 0; m_auto = 0;
                m_dead = 0; m_since = 0; m_cnt = 0; m_lvl = 0; m_edge = 0; m_hyst = 0; m_adq = 0;
            end else begin
                cyc = cyc + 1;
                model_step();
            end
        end
    end

    // compare every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge I_clk);
            chk("trigger",   bus.trigger,   m_fire);
            chk("auto_flag", bus.auto_flag, m_auto);
            chk("armed",     bus.armed,     m_search);
            chk("trig_cnt",  bus.trig_cnt,  m_cnt & 16'hFFFF);
            if (bus.trigger === 1'b1) begin
                if (prev_trig) wide = 1;
                if (pulse_n > 0 && cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
                if (pulse_n < 8) p_cyc[pulse_n] = cyc;
                last_cyc = cyc;
                pulse_n++;
            end
            prev_trig = (bus.trigger === 1'b1);
        end
    end

    task automatic tick();
        @(negedge I_clk);
    endtask

    task automatic clear_trk();
        pulse_n = 0; last_cyc = 0; min_gap = 1000000; wide = 0;
        for (int i = 0; i < 8; i++) p_cyc[i] = 0;
    endtask

    task automatic setup(input int lvl, input int edg, input int hy, input int ho, input int au);
        bus.trig_level = 8'(lvl);
        bus.trig_edge  = edg[0];
        bus.hyst       = 4'(hy);
        bus.holdoff    = 16'(ho);
        bus.auto_en    = au[0];
    endtask

    initial begin
        int drive_cyc, arm_cyc, v, len;
        bus.ad_data = 8'h00; bus.arm = 1'b0;
        setup(0, 0, 0, 0, 0);
        clear_trk();

        // reset state
        tick();
        chk("rst_trigger",   bus.trigger,   0);
        chk("rst_auto_flag", bus.auto_flag, 0);
        chk("rst_armed",     bus.armed,     0);
        chk("rst_trig_cnt",  bus.trig_cnt,  0);
        rst_n = 1'b1;

        // rising ramp through the level
        setup(8'h80, 0, 4, 0, 0);
        bus.ad_data = 8'h70; tick();
        bus.arm = 1'b1; tick(); tick();
        clear_trk();
        drive_cyc = 0;
        for (int k = 8'h70; k <= 8'h90; k++) begin
            bus.ad_data = 8'(k);
            if (k == 8'h80) drive_cyc = cyc;
            tick();
        end
        repeat (3) tick();
        chk("ramp_pulses",  pulse_n, 1);
        chk("ramp_latency", p_cyc[0] - drive_cyc, 2);
        chk("ramp_cnt",     bus.trig_cnt, 1);
        bus.arm = 1'b0; repeat (3) tick();

        // noise inside the hysteresis band, then a real dip and rise
        bus.ad_data = 8'h81; bus.arm = 1'b1; tick(); tick();
        clear_trk();
        for (int k = 0; k < 20; k++) begin
            bus.ad_data = (k % 2) ? 8'h7E : 8'h81;
            tick();
        end
        chk("noise_pulses", pulse_n, 0);
        bus.ad_data = 8'h7C; tick();
        bus.ad_data = 8'h80; tick();
        repeat (3) tick();
        chk("dip_pulses", pulse_n, 1);
        chk("dip_cnt",    bus.trig_cnt, 2);
        bus.arm = 1'b0; repeat (3) tick();

        // falling square wave with hold-off
        setup(8'h10, 1, 8, 20, 0);
        bus.ad_data = 8'h30; bus.arm = 1'b1;
        clear_trk();
        for (int k = 0; k < 200; k++) begin
            bus.ad_data = ((k / 4) % 2) ? 8'h00 : 8'h30;
            tick();
        end
        chk("sq_some_pulses", pulse_n >= 5, 1);
        chk("sq_min_gap",     min_gap >= 22, 1);
        chk("sq_one_wide",    wide, 0);
        bus.arm = 1'b0; repeat (3) tick();

        // auto-trigger on a flat input
        setup(8'h80, 0, 4, 10, 1);
        bus.ad_data = 8'h50; tick();
        clear_trk();
        bus.arm = 1'b1; arm_cyc = cyc;
        for (int k = 0; k < 400 && pulse_n < 3; k++) tick();
        chk("auto_pulses", pulse_n >= 3, 1);
        chk("auto_first",  p_cyc[0] - arm_cyc, 101);
        chk("auto_gap1",   p_cyc[1] - p_cyc[0], 111);
        chk("auto_gap2",   p_cyc[2] - p_cyc[1], 111);
        chk("auto_flag_d", bus.auto_flag, 1);
        bus.arm = 1'b0; repeat (3) tick();

        // arm dropped in the crossing cycle
        setup(8'h80, 0, 4, 0, 0);
        bus.ad_data = 8'h70; bus.arm = 1'b1; repeat (3) tick();
        clear_trk();
        bus.ad_data = 8'h90; tick();
        bus.arm = 1'b0; tick();
        repeat (2) tick();
        chk("drop_pulses", pulse_n, 0);
        chk("drop_armed",  bus.armed, 0);

        // reset asserted during hold-off
        setup(8'h80, 0, 4, 50, 0);
        bus.ad_data = 8'h70; bus.arm = 1'b1; repeat (3) tick();
        clear_trk();
        bus.ad_data = 8'h90; repeat (4) tick();
        chk("ho_pulses", pulse_n, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ho_rst_trigger",   bus.trigger,   0);
        chk("ho_rst_auto_flag", bus.auto_flag, 0);
        chk("ho_rst_armed",     bus.armed,     0);
        chk("ho_rst_trig_cnt",  bus.trig_cnt,  0);
        bus.arm = 1'b0; tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_idle", bus.armed, 0);

        // randomized episodes against the model
        for (int ep = 0; ep < 40; ep++) begin
            bus.arm = 1'b0; repeat (3) tick();
            setup($urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 15),
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30), $urandom_range(0, 1));
            bus.arm = 1'b1;
            v = $urandom_range(0, 255);
            len = $urandom_range(50, 300);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 19) == 0) v = $urandom_range(0, 255);
                else v = v + int'($urandom_range(0, 16)) - 8;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                bus.ad_data = 8'(v);
                bus.arm = ($urandom_range(0, 99) != 0);
                tick();
            end
        end
        bus.arm = 1'b0; repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
